// File: rtl/apx_fp_pkg.sv
// rtl/apx_fp_pkg.sv - shared states, constants and field helpers for the approximate float adder
// Contents: state_t FSM encoding, IEEE-754 single constants, NaN/inf/zero field tests.

package apx_fp_pkg;

    typedef enum logic [3:0] {
        GET_A,
        GET_B,
        UNPACK,
        SPECIAL,
        ALIGN,
        ADD0,
        ADD1,
        NORM1,
        NORM2,
        ROUND,
        PACK,
        PUT_Z
    } state_t;

    localparam logic [31:0]        QNAN       = 32'h7FC00000;
    localparam logic signed [9:0]  EXP_BIAS   = 10'sd127;
    localparam logic signed [9:0]  EXP_MIN    = -10'sd126;
    localparam logic signed [9:0]  EXP_MAX    = 10'sd127;
    localparam int                 MANT_EXT_W = 27;

    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic is_inf(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_zero(input logic [31:0] x);
        return x[30:0] == 31'd0;
    endfunction

endpackage

// File: rtl/apx_fp_round.sv
// rtl/apx_fp_round.sv - round-to-nearest-even step and IEEE-754 packing (combinational)
// Ports: m/e/sign - normalised significand, unbiased exponent, sign;
//        guard/round_bit/sticky - bits below m; rnd_m/rnd_e - rounded significand/exponent;
//        pack_z - packed single built from m/e/sign as presented.

module apx_fp_round
    import apx_fp_pkg::*;
(
    input  logic [23:0]        m,
    input  logic signed [9:0]  e,
    input  logic               sign,
    input  logic               guard,
    input  logic               round_bit,
    input  logic               sticky,
    output logic [23:0]        rnd_m,
    output logic signed [9:0]  rnd_e,
    output logic [31:0]        pack_z
);

    logic [7:0] exp_field;

    always_comb begin
        rnd_m = m;
        rnd_e = e;
        if (guard && (round_bit || sticky || m[0])) begin
            rnd_m = m + 24'd1;
            // All-ones wraps to zero; the value is 1.0 * 2^(e+1), which packs correctly
            // with a zero fraction and the bumped exponent.
            if (m == 24'hFFFFFF) begin
                rnd_e = e + 10'sd1;
            end
        end
    end

    always_comb begin
        exp_field = e[7:0] + 8'd127;
        pack_z    = {sign, exp_field, m[22:0]};
        if ((e == EXP_MIN) && !m[23]) begin
            pack_z[30:23] = 8'd0;
        end
        if (e > EXP_MAX) begin
            pack_z = {sign, 8'hFF, 23'd0};
        end
    end

endmodule

// File: rtl/apx_float_adder.sv
// rtl/apx_float_adder.sv - approximate IEEE-754 single-precision adder with stb/ack handshakes
// Ports: clk, rst (synchronous, active high);
//        input_a/input_a_stb/input_a_ack, input_b/input_b_stb/input_b_ack - operand handshakes;
//        output_z/output_z_stb/output_z_ack - registered result handshake.
// APX_BITS zeroes that many LSBs of both aligned 27-bit significands before the add.

module apx_float_adder
    import apx_fp_pkg::*;
#(
    parameter int APX_BITS = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        input_a_stb,
    output logic        input_a_ack,
    input  logic [31:0] input_b,
    input  logic        input_b_stb,
    output logic        input_b_ack,
    output logic [31:0] output_z,
    output logic        output_z_stb,
    input  logic        output_z_ack
);

    localparam logic [MANT_EXT_W-1:0] APX_MASK = ~((27'd1 << APX_BITS) - 27'd1);

    state_t state_q, state_d;

    logic [31:0]             a, b;
    logic [MANT_EXT_W-1:0]   a_m, b_m;
    logic signed [9:0]       a_e, b_e;
    logic                    a_s, b_s;
    logic [MANT_EXT_W:0]     sum;
    logic [23:0]             z_m;
    logic signed [9:0]       z_e;
    logic                    z_s;
    logic                    guard, round_bit, sticky;

    logic [MANT_EXT_W-1:0]   am_c, bm_c;
    logic                    special_hit;
    logic [31:0]             special_z;
    logic [23:0]             rnd_m;
    logic signed [9:0]       rnd_e;
    logic [31:0]             pack_z;

    assign am_c = a_m & APX_MASK;
    assign bm_c = b_m & APX_MASK;

    // Special operands are decided on the raw latched words, so denormal fix-up in
    // SPECIAL never affects which branch is taken.
    always_comb begin
        special_hit = 1'b1;
        special_z   = QNAN;
        if (is_nan(a) || is_nan(b)) begin
            special_z = QNAN;
        end else if (is_inf(a) && is_inf(b) && (a[31] != b[31])) begin
            special_z = QNAN;
        end else if (is_inf(a)) begin
            special_z = a;
        end else if (is_inf(b)) begin
            special_z = b;
        end else if (is_zero(a) && is_zero(b)) begin
            special_z = {a[31] & b[31], 31'd0};
        end else if (is_zero(a)) begin
            special_z = b;
        end else if (is_zero(b)) begin
            special_z = a;
        end else begin
            special_hit = 1'b0;
        end
    end

    apx_fp_round u_round (
        .m         (z_m),
        .e         (z_e),
        .sign      (z_s),
        .guard     (guard),
        .round_bit (round_bit),
        .sticky    (sticky),
        .rnd_m     (rnd_m),
        .rnd_e     (rnd_e),
        .pack_z    (pack_z)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= GET_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            GET_A:   if (input_a_ack && input_a_stb) state_d = GET_B;
            GET_B:   if (input_b_ack && input_b_stb) state_d = UNPACK;
            UNPACK:  state_d = SPECIAL;
            SPECIAL: state_d = special_hit ? PUT_Z : ALIGN;
            ALIGN:   if (a_e == b_e) state_d = ADD0;
            ADD0:    state_d = ADD1;
            ADD1:    state_d = NORM1;
            NORM1:   if (z_m[23] || (z_e <= EXP_MIN)) state_d = NORM2;
            NORM2:   if (z_e >= EXP_MIN) state_d = ROUND;
            ROUND:   state_d = PACK;
            PACK:    state_d = PUT_Z;
            PUT_Z:   if (output_z_stb && output_z_ack) state_d = GET_A;
            default: state_d = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            input_a_ack  <= 1'b0;
            input_b_ack  <= 1'b0;
            output_z_stb <= 1'b0;
            output_z     <= 32'd0;
            a            <= 32'd0;
            b            <= 32'd0;
            a_m          <= '0;
            b_m          <= '0;
            a_e          <= '0;
            b_e          <= '0;
            a_s          <= 1'b0;
            b_s          <= 1'b0;
            sum          <= '0;
            z_m          <= '0;
            z_e          <= '0;
            z_s          <= 1'b0;
            guard        <= 1'b0;
            round_bit    <= 1'b0;
            sticky       <= 1'b0;
        end else begin
            unique case (state_q)
                GET_A: begin
                    if (input_a_ack && input_a_stb) begin
                        a           <= input_a;
                        input_a_ack <= 1'b0;
                    end else begin
                        input_a_ack <= 1'b1;
                    end
                end
                GET_B: begin
                    if (input_b_ack && input_b_stb) begin
                        b           <= input_b;
                        input_b_ack <= 1'b0;
                    end else begin
                        input_b_ack <= 1'b1;
                    end
                end
                UNPACK: begin
                    a_m <= {1'b0, a[22:0], 3'b000};
                    b_m <= {1'b0, b[22:0], 3'b000};
                    a_e <= $signed({2'b00, a[30:23]}) - EXP_BIAS;
                    b_e <= $signed({2'b00, b[30:23]}) - EXP_BIAS;
                    a_s <= a[31];
                    b_s <= b[31];
                end
                SPECIAL: begin
                    if (special_hit) begin
                        output_z     <= special_z;
                        output_z_stb <= 1'b1;
                    end else begin
                        if (a[30:23] == 8'd0) a_e <= EXP_MIN;
                        else                  a_m[26] <= 1'b1;
                        if (b[30:23] == 8'd0) b_e <= EXP_MIN;
                        else                  b_m[26] <= 1'b1;
                    end
                end
                ALIGN: begin
                    // New bit0 keeps whatever falls off the end so the tail stays visible.
                    if (a_e > b_e) begin
                        b_e <= b_e + 10'sd1;
                        b_m <= {1'b0, b_m[26:2], b_m[1] | b_m[0]};
                    end else if (b_e > a_e) begin
                        a_e <= a_e + 10'sd1;
                        a_m <= {1'b0, a_m[26:2], a_m[1] | a_m[0]};
                    end
                end
                ADD0: begin
                    z_e <= a_e;
                    if (a_s == b_s) begin
                        sum <= {1'b0, am_c} + {1'b0, bm_c};
                        z_s <= a_s;
                    end else if (am_c > bm_c) begin
                        sum <= {1'b0, am_c} - {1'b0, bm_c};
                        z_s <= a_s;
                    end else if (bm_c > am_c) begin
                        sum <= {1'b0, bm_c} - {1'b0, am_c};
                        z_s <= b_s;
                    end else begin
                        sum <= '0;
                        z_s <= 1'b0;
                    end
                end
                ADD1: begin
                    if (sum[27]) begin
                        z_m       <= sum[27:4];
                        guard     <= sum[3];
                        round_bit <= sum[2];
                        sticky    <= sum[1] | sum[0];
                        z_e       <= z_e + 10'sd1;
                    end else begin
                        z_m       <= sum[26:3];
                        guard     <= sum[2];
                        round_bit <= sum[1];
                        sticky    <= sum[0];
                    end
                end
                NORM1: begin
                    if (!z_m[23] && (z_e > EXP_MIN)) begin
                        z_e       <= z_e - 10'sd1;
                        z_m       <= {z_m[22:0], guard};
                        guard     <= round_bit;
                        round_bit <= 1'b0;
                    end
                end
                NORM2: begin
                    if (z_e < EXP_MIN) begin
                        z_e       <= z_e + 10'sd1;
                        z_m       <= {1'b0, z_m[23:1]};
                        guard     <= z_m[0];
                        round_bit <= guard;
                        sticky    <= sticky | round_bit;
                    end
                end
                ROUND: begin
                    z_m <= rnd_m;
                    z_e <= rnd_e;
                end
                PACK: begin
                    output_z     <= pack_z;
                    output_z_stb <= 1'b1;
                end
                PUT_Z: begin
                    if (output_z_stb && output_z_ack) begin
                        output_z_stb <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apx_float_adder.sv
// tb/tb_apx_float_adder.sv - self-checking bench for apx_float_adder (APX_BITS 0 and 9)

module tb_apx_float_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_a [2];
    logic [31:0] in_b [2];
    logic [31:0] z_out [2];
    logic [1:0]  a_stb, a_ack, b_stb, b_ack, z_stb, z_ack;
    logic [1:0]  prev_stb;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];

    always #5 clk = ~clk;

    apx_float_adder #(.APX_BITS(0)) dut0 (
        .clk(clk), .rst(rst),
        .input_a(in_a[0]), .input_a_stb(a_stb[0]), .input_a_ack(a_ack[0]),
        .input_b(in_b[0]), .input_b_stb(b_stb[0]), .input_b_ack(b_ack[0]),
        .output_z(z_out[0]), .output_z_stb(z_stb[0]), .output_z_ack(z_ack[0])
    );

    apx_float_adder #(.APX_BITS(9)) dut9 (
        .clk(clk), .rst(rst),
        .input_a(in_a[1]), .input_a_stb(a_stb[1]), .input_a_ack(a_ack[1]),
        .input_b(in_b[1]), .input_b_stb(b_stb[1]), .input_b_ack(b_ack[1]),
        .output_z(z_out[1]), .output_z_stb(z_stb[1]), .output_z_ack(z_ack[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
    endtask

    function automatic int apx_of(input int k);
        return (k == 0) ? 0 : 9;
    endfunction

    // Right shift by d, folding every discarded bit into bit0.
    function automatic longint shr_sticky(input longint m, input int d);
        if (d == 0) return m;
        if (d >= 40) return (m != 0) ? 64'd1 : 64'd0;
        return (m >> d) | (((m & ((64'd1 << d) - 1)) != 0) ? 64'd1 : 64'd0);
    endfunction

    // Round the exact value S * 2^(E-26) to the nearest single (ties to even).
    function automatic logic [31:0] rne_pack(input logic s, input longint S, input int E);
        int p, lead, ex, sh;
        longint q, rem, half;
        if (S == 0) return {s, 31'd0};
        p = 0;
        for (int i = 0; i < 40; i++) if (S[i]) p = i;
        lead = E - 26 + p;
        ex   = (lead < -126) ? -126 : lead;
        sh   = ex - E + 3;
        if (sh <= 0) begin
            q = S << (-sh);
        end else begin
            q    = S >> sh;
            rem  = S & ((64'd1 << sh) - 1);
            half = 64'd1 << (sh - 1);
            if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
        end
        if (q >= (64'd1 << 24)) begin
            q  = q >> 1;
            ex = ex + 1;
        end
        if (ex > 127) return {s, 8'hFF, 23'd0};
        if (q < (64'd1 << 23)) return {s, 8'd0, q[22:0]};
        return {s, 8'(ex + 127), q[22:0]};
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b, input int apx);
        int     ea, eb, xa, xb, e_al;
        longint fa, fb, ma, mb, mask, S;
        logic   sa, sb, s;
        logic   nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        fa = 64'(a[22:0]);   fb = 64'(b[22:0]);
        sa = a[31];          sb = b[31];
        nan_a = (ea == 255) && (fa != 0);  nan_b = (eb == 255) && (fb != 0);
        inf_a = (ea == 255) && (fa == 0);  inf_b = (eb == 255) && (fb == 0);
        zer_a = (ea == 0) && (fa == 0);    zer_b = (eb == 0) && (fb == 0);
        if (nan_a || nan_b) return 32'h7FC00000;
        if (inf_a && inf_b && (sa != sb)) return 32'h7FC00000;
        if (inf_a) return a;
        if (inf_b) return b;
        if (zer_a && zer_b) return {sa & sb, 31'd0};
        if (zer_a) return b;
        if (zer_b) return a;
        ma = ((ea == 0) ? fa : (fa | (64'd1 << 23))) << 3;
        mb = ((eb == 0) ? fb : (fb | (64'd1 << 23))) << 3;
        xa = (ea == 0) ? -126 : ea - 127;
        xb = (eb == 0) ? -126 : eb - 127;
        if (xa < xb) begin
            ma = shr_sticky(ma, xb - xa);
            e_al = xb;
        end else begin
            mb = shr_sticky(mb, xa - xb);
            e_al = xa;
        end
        mask = ~((64'd1 << apx) - 1);
        ma = ma & mask;
        mb = mb & mask;
        if (sa == sb)     begin S = ma + mb; s = sa;   end
        else if (ma > mb) begin S = ma - mb; s = sa;   end
        else if (mb > ma) begin S = mb - ma; s = sb;   end
        else              begin S = 0;       s = 1'b0; end
        return rne_pack(s, S, e_al);
    endfunction

    // One compare process: whenever a result strobe is up, it must match the
    // oldest outstanding model value; the entry retires when the strobe falls.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                if (k == 0) exp_q0.delete(); else exp_q1.delete();
                prev_stb[k] <= 1'b0;
            end else begin
                if (z_stb[k]) begin
                    if (((k == 0) ? exp_q0.size() : exp_q1.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_stb: dut%0d strobed %h with nothing outstanding", k, z_out[k]);
                    end else begin
                        chk("model_vs_dut", z_out[k], (k == 0) ? exp_q0[0] : exp_q1[0]);
                    end
                end else if (prev_stb[k]) begin
                    if (k == 0 && exp_q0.size() > 0) exp_q0.delete(0);
                    if (k == 1 && exp_q1.size() > 0) exp_q1.delete(0);
                end
                prev_stb[k] <= z_stb[k];
            end
        end
    end

    // Operand handshake; entered and left at a falling edge.
    task automatic send(input int k, input bit is_b, input logic [31:0] val);
        int n = 0;
        if (is_b) begin in_b[k] = val; b_stb[k] = 1'b1; end
        else      begin in_a[k] = val; a_stb[k] = 1'b1; end
        while (!(is_b ? b_ack[k] : a_ack[k]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) fail_now(is_b ? "ack_b" : "ack_a");
        @(posedge clk);
        #1;
        if (is_b) b_stb[k] = 1'b0; else a_stb[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_add(input int k, input logic [31:0] a, input logic [31:0] b,
                           input int hold_b, input int hold_ack,
                           input bit use_lit, input logic [31:0] lit);
        int n = 0;
        logic [31:0] held;
        if (use_lit) chk("model_pin", model_add(a, b, apx_of(k)), lit);
        if (k == 0) exp_q0.push_back(model_add(a, b, 0));
        else        exp_q1.push_back(model_add(a, b, 9));
        send(k, 1'b0, a);
        if (hold_b > 0) begin
            repeat (hold_b) @(negedge clk);
            chk("wait_in_get_b", 32'({a_ack[k], b_ack[k], z_stb[k]}), 32'b010);
        end
        send(k, 1'b1, b);
        while (!z_stb[k] && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!z_stb[k]) begin
            fail_now("result_stb");
            return;
        end
        if (use_lit) chk("literal_result", z_out[k], lit);
        held = z_out[k];
        for (int i = 0; i < hold_ack; i++) begin
            @(negedge clk);
            chk("hold_stb", 32'(z_stb[k]), 32'd1);
            chk("hold_z", z_out[k], held);
        end
        z_ack[k] = 1'b1;
        @(posedge clk);
        #1;
        z_ack[k] = 1'b0;
        @(negedge clk);
        chk("stb_cleared", 32'(z_stb[k]), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        int ea, eb;
        rst = 1'b1;
        a_stb = '0; b_stb = '0; z_ack = '0;
        for (int k = 0; k < 2; k++) begin
            in_a[k] = 32'd0;
            in_b[k] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("reset_a_ack", 32'(a_ack[k]), 32'd0);
            chk("reset_b_ack", 32'(b_ack[k]), 32'd0);
            chk("reset_z_stb", 32'(z_stb[k]), 32'd0);
            chk("reset_z", z_out[k], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("get_a_ready", 32'(a_ack[k]), 32'd1);

        run_add(0, 32'h3F800000, 32'h40000000, 0, 0, 1'b1, 32'h40400000);
        run_add(0, 32'h4AFFFFFE, 32'h41A0CCCD, 0, 0, 1'b1, 32'h4B000013);
        run_add(1, 32'h4AFFFFFE, 32'h41A0CCCD, 0, 0, 1'b1, 32'h4AFFFFC0);
        run_add(1, 32'h3F800000, 32'h40000000, 0, 0, 1'b1, 32'h40400000);
        run_add(0, 32'h40000000, 32'hC0000000, 0, 0, 1'b1, 32'h00000000);
        run_add(0, 32'h80000000, 32'h80000000, 0, 0, 1'b1, 32'h80000000);
        run_add(0, 32'h7FC00001, 32'h3F800000, 0, 0, 1'b1, 32'h7FC00000);
        run_add(0, 32'h7F800000, 32'hFF800000, 0, 0, 1'b1, 32'h7FC00000);
        run_add(0, 32'h7F800000, 32'h3F800000, 0, 0, 1'b1, 32'h7F800000);
        run_add(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 0, 1'b1, 32'h7F800000);
        run_add(0, 32'h00000001, 32'h80800000, 0, 0, 1'b1, 32'h807FFFFF);
        run_add(0, 32'h3F800000, 32'h40000000, 20, 10, 1'b1, 32'h40400000);

        // Reset while a long alignment is under way.
        send(0, 1'b0, 32'h7F000000);
        send(0, 1'b1, 32'h00800000);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_a_ack", 32'(a_ack[0]), 32'd0);
        chk("midrst_b_ack", 32'(b_ack[0]), 32'd0);
        chk("midrst_z_stb", 32'(z_stb[0]), 32'd0);
        chk("midrst_z", z_out[0], 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_get_a", 32'({a_ack[0], b_ack[0]}), 32'b10);
        run_add(0, 32'hC0A00000, 32'h3FC00000, 0, 0, 1'b1, 32'hC0600000);

        for (int i = 0; i < 200; i++) begin
            ea = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(90, 170));
            ra = {1'($urandom_range(0, 1)), 8'(ea), 23'($urandom)};
            if ($urandom_range(0, 1) == 1) eb = ea + int'($urandom_range(0, 2)) - 1;
            else                           eb = int'($urandom_range(0, 200));
            if (eb < 0) eb = 0;
            if (eb > 254) eb = 254;
            rb = {1'($urandom_range(0, 1)), 8'(eb), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) rb = {~ra[31], ra[30:0] ^ 31'($urandom_range(0, 7))};
            if ($urandom_range(0, 15) == 0) rb = $urandom;
            run_add(i % 2, ra, rb, 0, int'($urandom_range(0, 2)), 1'b0, 32'd0);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
